// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types for the bitstream serializer.
// FSM states, carry-flag codes, the command entry and a final-byte helper.
package serializer_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    S_B1,
    S_B2,
    S_B3,
    S_RUN,
    S_B4,
    S_B5
  } state_e;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_B1,
    CF_B2,
    CF_B3,
    CF_B4,
    CF_RUN,
    CF_RUN_B4,
    CF_RUN_B5
  } carry_flag_e;

  typedef struct packed {
    carry_flag_e flag;
    logic        last;
    byte_t       b1;
    byte_t       b2;
    byte_t       b3;
    byte_t       b4;
    byte_t       b5;
  } cmd_t;

  // True when the byte emitted in state st closes the group.
  function automatic logic is_final(
    input state_e st,
    input cmd_t   c,
    input byte_t  cnt
  );
    logic f;
    f = 1'b0;
    unique case (st)
      S_B1:  f = (c.flag == CF_B1) ||
                 (c.flag == CF_RUN && c.b3 == '0);
      S_B2:  f = (c.flag == CF_B2);
      S_B3:  f = (c.flag == CF_B3);
      S_RUN: f = (c.flag == CF_RUN) && (cnt == 8'd1);
      S_B4:  f = (c.flag == CF_B4) ||
                 (c.flag == CF_RUN_B4);
      S_B5:  f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serializer_cmd_fifo.sv
// serializer_cmd_fifo: command FIFO, show-ahead read port.
// Pointers carry one extra bit to tell full from empty.
module serializer_cmd_fifo
  import serializer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic full,
  output logic empty,
  output logic almost_full
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t used;
  T     mem_q [DEPTH];
  T     mem_d [DEPTH];

  assign used        = wr_ptr_q - rd_ptr_q;
  assign full        = (used == ptr_t'(DEPTH));
  assign empty       = (used == '0);
  assign almost_full = (used >= ptr_t'(DEPTH - 1));
  assign rd_data     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: expands carry groups into a byte stream.
// BITSTREAM_SERIALIZER_COUNT_EN adds the accepted-byte counter port.
module bitstream_serializer
  import serializer_pkg::*;
#(
  parameter int S5_BITSTREAM_WIDTH = 8,
  parameter int S5_CMD_DEPTH       = 4
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
  input  logic [2:0]                    in_carry_flag,
  input  logic                          in_flag_last,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_almost_full,
  output logic                          out_overflow
`ifdef BITSTREAM_SERIALIZER_COUNT_EN
  ,
  output logic [31:0]                   out_byte_count
`endif
);

  state_e state_q, state_d, nxt;
  cmd_t   cur_q, cur_d;
  byte_t  cnt_q, cnt_d, cnt_n;
  byte_t  byte_q, byte_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;
  logic   ovf_q, ovf_d;
  logic   fire, pop, wr_en;
  logic   fifo_full, fifo_empty;
  cmd_t   cmd_wr, rd_data;

  assign fire  = valid_q && out_ready;
  assign wr_en = (in_carry_flag != 3'd0) && !fifo_full;
  assign ovf_d = ovf_q ||
                 ((in_carry_flag != 3'd0) && fifo_full);

  always_comb begin
    cmd_wr      = '0;
    cmd_wr.flag = carry_flag_e'(in_carry_flag);
    cmd_wr.last = in_flag_last;
    cmd_wr.b1   = BYTE_W'(in_carry_bit_1);
    cmd_wr.b2   = BYTE_W'(in_carry_bit_2);
    cmd_wr.b3   = BYTE_W'(in_carry_bit_3);
    cmd_wr.b4   = BYTE_W'(in_carry_bit_4);
    cmd_wr.b5   = BYTE_W'(in_carry_bit_5);
  end

  serializer_cmd_fifo #(
    .DEPTH (S5_CMD_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk         (s5_clk),
    .rst_n       (s5_reset),
    .wr_en       (wr_en),
    .wr_data     (cmd_wr),
    .rd_en       (pop),
    .rd_data     (rd_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (out_almost_full)
  );

  // Successor of the byte currently on the output; IDLE ends the group.
  always_comb begin
    nxt   = IDLE;
    cnt_n = cnt_q;
    unique case (state_q)
      S_B1: begin
        if (cur_q.flag == CF_B1) begin
          nxt = IDLE;
        end else if (cur_q.flag <= CF_B4) begin
          nxt = S_B2;
        end else if (cur_q.b3 == '0) begin
          nxt = (cur_q.flag == CF_RUN) ? IDLE : S_B4;
        end else begin
          nxt   = S_RUN;
          cnt_n = cur_q.b3;
        end
      end
      S_B2: nxt = (cur_q.flag == CF_B2) ? IDLE : S_B3;
      S_B3: nxt = (cur_q.flag == CF_B3) ? IDLE : S_B4;
      S_RUN: begin
        cnt_n = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          nxt = (cur_q.flag == CF_RUN) ? IDLE : S_B4;
        end else begin
          nxt = S_RUN;
        end
      end
      S_B4: nxt = (cur_q.flag == CF_RUN_B5) ? S_B5 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop     = 1'b0;
    if (state_q == IDLE || fire) begin
      if (nxt == IDLE) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = rd_data;
          state_d = S_B1;
          byte_d  = rd_data.b1;
          valid_d = 1'b1;
          last_d  = rd_data.last &&
                    is_final(S_B1, rd_data, cnt_q);
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end else begin
        state_d = nxt;
        cnt_d   = cnt_n;
        valid_d = 1'b1;
        last_d  = cur_q.last &&
                  is_final(nxt, cur_q, cnt_n);
        unique case (nxt)
          S_B2, S_RUN: byte_d = cur_q.b2;
          S_B3:        byte_d = cur_q.b3;
          S_B4:        byte_d = cur_q.b4;
          S_B5:        byte_d = cur_q.b5;
          default:     byte_d = cur_q.b1;
        endcase
      end
    end
  end

  always_ff @(posedge s5_clk or negedge s5_reset) begin
    if (!s5_reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_byte     = S5_BITSTREAM_WIDTH'(byte_q);
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign out_overflow = ovf_q;

`ifdef BITSTREAM_SERIALIZER_COUNT_EN
  logic [31:0] bcnt_q, bcnt_d;

  assign bcnt_d = bcnt_q + (fire ? 32'd1 : 32'd0);

  always_ff @(posedge s5_clk or negedge s5_reset) begin
    if (!s5_reset) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign out_byte_count = bcnt_q;
`endif

endmodule

// File: doc/bitstream_serializer.md
BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 SHALL have parameter S5_BITSTREAM_WIDTH, default 8, meaning the byte width of every data port.
REQ-002 SHALL have parameter S5_CMD_DEPTH, default 4, meaning the number of command-FIFO entries (power of 2, at least 2).
REQ-003 SHALL have ports, one per line:
- s5_clk  in  1  the only clock.
- s5_reset  in  1  asynchronous, active-low reset.
- in_carry_bit_1..in_carry_bit_5  in  8 each  byte slots from carry propagation.
- in_carry_flag  in  3  group code: 0 = none, 1-7 = group type.
- in_flag_last  in  1  the group is the final one of the frame.
- out_byte  out  8  serialized byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  the consumer accepts the byte.
- out_last  out  1  the final byte of the frame.
- out_almost_full  out  1  command FIFO has at most 1 free entry.
- out_overflow  out  1  sticky error.

Function
REQ-004 SHALL capture a group into the command FIFO in every cycle where in_carry_flag != 0 and the FIFO is not full; flag 0 is ignored and writes nothing.
REQ-005 SHALL emit bytes in this order for each flag value:
- Flag 1: b1.
- Flag 2: b1, b2.
- Flag 3: b1, b2, b3.
- Flag 4: b1, b2, b3, b4.
- Flag 5: b1, then b2 repeated b3 times.
- Flag 6: the flag-5 sequence, then b4.
- Flag 7: the flag-6 sequence, then b5.
REQ-006 SHALL treat b3 = 0 for flags 5-7 as a zero-length run, so b1 is followed directly by b4/b5 or by the end of the group.
REQ-007 SHALL use an FSM with states IDLE, S_B1, S_B2, S_B3, S_RUN, S_B4, S_B5; the FSM advances only on a cycle where out_valid && out_ready, and leaves IDLE when the FIFO is not empty.
REQ-008 SHALL load an 8-bit run counter with b3 when entering S_RUN, decrement it per accepted byte, and exit S_RUN when the counter reaches 1.
REQ-009 SHALL register out_byte, out_valid and out_last; a group written in cycle N produces its first byte with out_valid high at edge N+1 when the FIFO was empty and the FSM was idle.
REQ-010 SHALL sustain 1 byte per cycle while out_ready=1, with no bubble between consecutive groups.
REQ-011 SHALL hold out_byte, out_valid and out_last stable while out_valid && !out_ready.
REQ-012 SHALL assert out_last only with the final byte of a group captured with in_flag_last=1; in_flag_last is ignored when in_carry_flag=0.
REQ-013 SHALL, for a simultaneous FIFO write and FSM pop in the same cycle, leave the occupancy unchanged and complete both operations.
REQ-014 SHALL, on in_carry_flag != 0 while the FIFO is full, drop the group and set out_overflow, which stays set until reset.
REQ-015 SHALL wrap the FIFO read and write pointers modulo S5_CMD_DEPTH, and distinguish full from empty with an extra pointer bit.

Reset
REQ-016 SHALL, while s5_reset=0, asynchronously force FSM=IDLE, FIFO empty, run counter=0, out_byte=0, out_valid=0, out_last=0, out_overflow=0, and out_almost_full=0.
REQ-017 SHALL discard any partially emitted group on reset mid-operation and emit nothing from it after reset release.

Configuration
REQ-018 SHALL, when BITSTREAM_SERIALIZER_COUNT_EN is defined, add output out_byte_count (32 bits, reset 0) that increments on every accepted byte and wraps at 2^32.
REQ-019 SHALL, when BITSTREAM_SERIALIZER_COUNT_EN is undefined, omit the out_byte_count port and counter entirely, with all other behaviour identical.

Structure
REQ-020 SHALL place the FSM state enum, the carry-flag enum (0-7) and the command-entry struct {flag, last, b1..b5} in shared package serializer_pkg.
REQ-021 SHALL implement the command FIFO as sub-module serializer_cmd_fifo, parameterized by depth and entry type; the FSM and output registers SHALL stay in bitstream_serializer.

Verification
REQ-022 SHALL cover: flag 3 with b1..b3 = 0x10, 0x20, 0x30 and out_ready=1 -> bytes 0x10, 0x20, 0x30 on 3 consecutive cycles starting 1 cycle after input.
REQ-023 SHALL cover: flag 7 with b1=0xA0, b2=0xFF, b3=3, b4=0x01, b5=0x02 -> sequence A0, FF, FF, FF, 01, 02.
REQ-024 SHALL cover: flag 6 with b3=0, b1=0x11, b4=0x22 -> sequence 11, 22 only.
REQ-025 SHALL cover: out_ready=0 for 5 cycles mid-group -> out_byte held; 5 more flag-1 groups -> out_almost_full asserted, then out_overflow=1 with the dropped group never emitted.
REQ-026 SHALL cover: flag 2 with in_flag_last=1 -> out_last high only on the second byte; a flag-1 group with in_flag_last=1 and flag-0 cycles in between -> out_last high only on the flag-1 byte.
REQ-027 SHALL cover: s5_reset pulled low during the S_RUN of a flag-5 group with b3=200 -> all outputs 0 immediately, and no stale byte after release.
